// File: rtl/dm_debug_arbiter_pkg.sv
// Shared DMType codes and debug scan FSM encodings for the data-memory debug arbiter.
package dm_debug_arbiter_pkg;

  // DMType codes understood by the dm instance
  localparam logic [2:0] DM_TYPE_WORD     = 3'b000;
  localparam logic [2:0] DM_TYPE_HALF     = 3'b001;
  localparam logic [2:0] DM_TYPE_HALF_U   = 3'b010;
  localparam logic [2:0] DM_TYPE_BYTE     = 3'b011;
  localparam logic [2:0] DM_TYPE_BYTE_U   = 3'b100;

  // Debug scan sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/dm_debug_arbiter_if.sv
// Data-memory bus bundle: the requester drives strobes/address/data, the memory returns rdata.
interface dm_debug_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);

  logic              we;
  logic              re;
  logic [2:0]        dtype;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output we, re, dtype, addr, wdata, input rdata);
  modport slave  (input we, re, dtype, addr, wdata, output rdata);

endinterface

// File: rtl/dm_debug_scan_seq.sv
// Debug scan sequencer: request/hold FSM, dwell counter and scan word-address register.
import dm_debug_arbiter_pkg::*;

module dm_debug_scan_seq #(
  parameter int DATA_W      = 32,
  parameter int SCAN_WORDS  = 32,
  parameter int HOLD_CYCLES = 4,
  localparam int IDX_W      = $clog2(SCAN_WORDS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              scan_en,
  input  logic              pause,
  input  logic              load,
  input  logic [IDX_W-1:0]  load_addr,
  input  logic              grant,
  input  logic [DATA_W-1:0] capture_data,
  output logic              scan_req,
  output logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_valid
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

  logic [1:0]      state;
  logic [HC_W-1:0] hold_cnt;

  assign scan_req = (state == ST_REQ);

  // FSM, dwell counter, capture register and address; a load always overrides the advance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      dbg_addr  <= '0;
      dbg_data  <= '0;
      dbg_valid <= 1'b0;
    end else begin
      dbg_valid <= 1'b0;
      if (!scan_en) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: state <= ST_REQ;
          ST_REQ: begin
            if (grant) begin
              dbg_data  <= capture_data;
              dbg_valid <= 1'b1;
              hold_cnt  <= '0;
              state     <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (load) begin
              hold_cnt <= '0;
              state    <= ST_REQ;
            end else if (hold_cnt == HOLD_LAST) begin
              state <= ST_REQ;
              if (!pause) dbg_addr <= dbg_addr + 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
      if (load) dbg_addr <= load_addr;
    end
  end

endmodule

// File: rtl/dm_debug_arbiter.sv
// Data-memory port arbiter: CPU has absolute priority, the debug scanner borrows idle cycles.
// Optional feature macro: DM_DEBUG_ARB_STATS_EN adds the saturating conflict_cnt_o counter.
import dm_debug_arbiter_pkg::*;

module dm_debug_arbiter #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int SCAN_WORDS  = 32,
  parameter int HOLD_CYCLES = 4,
  localparam int IDX_W      = $clog2(SCAN_WORDS)
) (
  input  logic               clk,
  input  logic               rstn,
  dm_debug_arbiter_if.slave  cpu,
  dm_debug_arbiter_if.master dm,
  input  logic               dbg_scan_en,
  input  logic               dbg_pause,
  input  logic               dbg_load,
  input  logic [IDX_W-1:0]   dbg_load_addr,
  output logic [IDX_W-1:0]   dbg_addr_o,
  output logic [DATA_W-1:0]  dbg_data_o,
  output logic               dbg_valid_o
`ifdef DM_DEBUG_ARB_STATS_EN
  ,
  output logic [15:0]        conflict_cnt_o
`endif
);

  logic              slot_free;
  logic              scan_req;
  logic              grant;
  logic [ADDR_W-1:0] dbg_byte_addr;

  assign slot_free     = ~cpu.we & ~cpu.re;
  assign grant         = slot_free & scan_req;
  assign dbg_byte_addr = ADDR_W'({dbg_addr_o, 2'b00});

  assign dm.we    = cpu.we;
  assign dm.wdata = cpu.wdata;
  assign dm.re    = cpu.re | grant;
  assign dm.addr  = grant ? dbg_byte_addr : cpu.addr;
  assign dm.dtype = grant ? DM_TYPE_WORD : cpu.dtype;
  assign cpu.rdata = dm.rdata;

  dm_debug_scan_seq #(
    .DATA_W      (DATA_W),
    .SCAN_WORDS  (SCAN_WORDS),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_seq (
    .clk          (clk),
    .rstn         (rstn),
    .scan_en      (dbg_scan_en),
    .pause        (dbg_pause),
    .load         (dbg_load),
    .load_addr    (dbg_load_addr),
    .grant        (grant),
    .capture_data (dm.rdata),
    .scan_req     (scan_req),
    .dbg_addr     (dbg_addr_o),
    .dbg_data     (dbg_data_o),
    .dbg_valid    (dbg_valid_o)
  );

`ifdef DM_DEBUG_ARB_STATS_EN
  // Count cycles where the scanner wanted the port but the CPU held it, saturating at all-ones
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      conflict_cnt_o <= '0;
    end else if (scan_req && !slot_free && (conflict_cnt_o != 16'hFFFF)) begin
      conflict_cnt_o <= conflict_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_debug_arbiter.sv
// Directed testbench for dm_debug_arbiter with a word-addressed memory model behind the dm port.
module tb_dm_debug_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        dbg_scan_en;
  logic        dbg_pause;
  logic        dbg_load;
  logic [4:0]  dbg_load_addr;
  logic [4:0]  dbg_addr_o;
  logic [31:0] dbg_data_o;
  logic        dbg_valid_o;
`ifdef DM_DEBUG_ARB_STATS_EN
  logic [15:0] conflict_cnt_o;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mem [0:127];

  dm_debug_arbiter_if #(.ADDR_W(9), .DATA_W(32)) cpu_bus ();
  dm_debug_arbiter_if #(.ADDR_W(9), .DATA_W(32)) dm_bus ();

  dm_debug_arbiter #(
    .ADDR_W(9), .DATA_W(32), .SCAN_WORDS(32), .HOLD_CYCLES(4)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .cpu            (cpu_bus.slave),
    .dm             (dm_bus.master),
    .dbg_scan_en    (dbg_scan_en),
    .dbg_pause      (dbg_pause),
    .dbg_load       (dbg_load),
    .dbg_load_addr  (dbg_load_addr),
    .dbg_addr_o     (dbg_addr_o),
    .dbg_data_o     (dbg_data_o),
    .dbg_valid_o    (dbg_valid_o)
`ifdef DM_DEBUG_ARB_STATS_EN
    ,
    .conflict_cnt_o (conflict_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, word store on the rising edge
  assign dm_bus.rdata = mem[dm_bus.addr[8:2]];
  always @(posedge clk) begin
    if (dm_bus.we) mem[dm_bus.addr[8:2]] <= dm_bus.wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_bus.we    = 1'b0;
    cpu_bus.re    = 1'b0;
    cpu_bus.dtype = 3'b000;
    cpu_bus.addr  = 9'h010;
    cpu_bus.wdata = 32'h0;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    cpu_bus.re    = 1'b1;
    cpu_bus.addr  = 9'h0A4;
    cpu_bus.dtype = 3'b011;
    #1;
    tests_run++;
    if (dbg_addr_o !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_addr: got %0d expected 0", dbg_addr_o); end
    tests_run++;
    if (dbg_data_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_data: got %h expected 0", dbg_data_o); end
    tests_run++;
    if (dbg_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", dbg_valid_o); end
    tests_run++;
    if (dm_bus.addr !== 9'h0A4) begin tests_failed++; $display("[TB] FAIL reset_dm_addr: got %h expected 0a4", dm_bus.addr); end
    tests_run++;
    if (dm_bus.dtype !== 3'b011) begin tests_failed++; $display("[TB] FAIL reset_dm_type: got %b expected 011", dm_bus.dtype); end
    tests_run++;
    if (dm_bus.re !== 1'b1 || dm_bus.we !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_strobes: got re=%b we=%b expected re=1 we=0", dm_bus.re, dm_bus.we); end
    tests_run++;
    if (cpu_bus.rdata !== 32'hA5000029) begin tests_failed++; $display("[TB] FAIL reset_cpu_rdata: got %h expected a5000029", cpu_bus.rdata); end
`ifdef DM_DEBUG_ARB_STATS_EN
    tests_run++;
    if (conflict_cnt_o !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_conflict: got %0d expected 0", conflict_cnt_o); end
`endif
    cpu_idle();
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_scan();
    dbg_load = 1'b1;
    dbg_load_addr = 5'd3;
    step();
    dbg_load = 1'b0;
    dbg_scan_en = 1'b1;
    step();
    tests_run++;
    if (dm_bus.addr !== 9'd12 || dm_bus.re !== 1'b1 || dm_bus.dtype !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL scan_grant_mux: got addr=%0d re=%b type=%b expected addr=12 re=1 type=000", dm_bus.addr, dm_bus.re, dm_bus.dtype);
    end
    step();
    tests_run++;
    if (dbg_data_o !== 32'hDEADBEEF || dbg_valid_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL scan_first_capture: got data=%h valid=%b expected deadbeef/1", dbg_data_o, dbg_valid_o);
    end
    for (int i = 1; i <= 10; i++) begin
      step();
      tests_run++;
      if (dbg_valid_o !== (i == 5 || i == 10)) begin
        tests_failed++;
        $display("[TB] FAIL scan_valid_cycle%0d: got %b expected %b", i, dbg_valid_o, (i == 5 || i == 10));
      end
      if (i == 4 || i == 9) begin
        tests_run++;
        if (dbg_addr_o !== ((i == 4) ? 5'd4 : 5'd5)) begin
          tests_failed++;
          $display("[TB] FAIL scan_addr_step%0d: got %0d expected %0d", i, dbg_addr_o, (i == 4) ? 4 : 5);
        end
      end
      if (i == 5 || i == 10) begin
        tests_run++;
        if (dbg_data_o !== ((i == 5) ? 32'hA5000004 : 32'hA5000005)) begin
          tests_failed++;
          $display("[TB] FAIL scan_data_step%0d: got %h", i, dbg_data_o);
        end
      end
    end
  endtask

  task automatic test_conflict();
    for (int i = 0; i < 4; i++) step();
    cpu_bus.re    = 1'b1;
    cpu_bus.addr  = 9'h040;
    cpu_bus.dtype = 3'b010;
    for (int i = 0; i < 10; i++) begin
      #1;
      tests_run++;
      if (dm_bus.addr !== 9'h040 || dm_bus.dtype !== 3'b010 || cpu_bus.rdata !== 32'hA5000010) begin
        tests_failed++;
        $display("[TB] FAIL conflict_cpu_path%0d: got addr=%h type=%b rdata=%h expected 040/010/a5000010", i, dm_bus.addr, dm_bus.dtype, cpu_bus.rdata);
      end
      step();
      tests_run++;
      if (dbg_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL conflict_no_capture%0d: got %b expected 0", i, dbg_valid_o); end
    end
    cpu_idle();
    #1;
    tests_run++;
    if (dm_bus.addr !== 9'd24 || dm_bus.re !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL conflict_free_grant: got addr=%0d re=%b expected 24/1", dm_bus.addr, dm_bus.re);
    end
    step();
    tests_run++;
    if (dbg_valid_o !== 1'b1 || dbg_data_o !== 32'hA5000006) begin
      tests_failed++;
      $display("[TB] FAIL conflict_late_capture: got valid=%b data=%h expected 1/a5000006", dbg_valid_o, dbg_data_o);
    end
`ifdef DM_DEBUG_ARB_STATS_EN
    tests_run++;
    if (conflict_cnt_o !== 16'd10) begin tests_failed++; $display("[TB] FAIL conflict_count: got %0d expected 10", conflict_cnt_o); end
`endif
    step();
    tests_run++;
    if (dbg_valid_o !== 1'b0 || dm_bus.re !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL hold_quiet: got valid=%b re=%b expected 0/0", dbg_valid_o, dm_bus.re);
    end
  endtask

  task automatic test_wrap_pause();
    dbg_load = 1'b1;
    dbg_load_addr = 5'd31;
    step();
    dbg_load = 1'b0;
    step();
    tests_run++;
    if (dbg_data_o !== 32'hA500001F) begin tests_failed++; $display("[TB] FAIL wrap_capture31: got %h expected a500001f", dbg_data_o); end
    for (int i = 0; i < 4; i++) step();
    tests_run++;
    if (dbg_addr_o !== 5'd0) begin tests_failed++; $display("[TB] FAIL wrap_addr: got %0d expected 0", dbg_addr_o); end
    step();
    tests_run++;
    if (dbg_data_o !== 32'hA5000000 || dbg_valid_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wrap_capture0: got data=%h valid=%b expected a5000000/1", dbg_data_o, dbg_valid_o);
    end
    dbg_load = 1'b1;
    dbg_pause = 1'b1;
    step();
    dbg_load = 1'b0;
    step();
    tests_run++;
    if (dbg_valid_o !== 1'b1 || dbg_data_o !== 32'hA500001F) begin
      tests_failed++;
      $display("[TB] FAIL pause_capture: got valid=%b data=%h expected 1/a500001f", dbg_valid_o, dbg_data_o);
    end
    cpu_bus.we    = 1'b1;
    cpu_bus.addr  = 9'd124;
    cpu_bus.wdata = 32'h12345678;
    cpu_bus.dtype = 3'b000;
    #1;
    tests_run++;
    if (dm_bus.we !== 1'b1 || dm_bus.wdata !== 32'h12345678 || dm_bus.addr !== 9'd124) begin
      tests_failed++;
      $display("[TB] FAIL pause_cpu_store: got we=%b din=%h addr=%0d expected 1/12345678/124", dm_bus.we, dm_bus.wdata, dm_bus.addr);
    end
    step();
    cpu_idle();
    for (int i = 0; i < 3; i++) step();
    tests_run++;
    if (dbg_addr_o !== 5'd31 || dbg_valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL pause_addr_hold: got addr=%0d valid=%b expected 31/0", dbg_addr_o, dbg_valid_o);
    end
    step();
    tests_run++;
    if (dbg_valid_o !== 1'b1 || dbg_data_o !== 32'h12345678) begin
      tests_failed++;
      $display("[TB] FAIL pause_recapture: got valid=%b data=%h expected 1/12345678", dbg_valid_o, dbg_data_o);
    end
  endtask

  task automatic test_load();
    dbg_pause = 1'b0;
    dbg_load = 1'b1;
    dbg_load_addr = 5'd7;
    step();
    dbg_load = 1'b0;
    step();
    tests_run++;
    if (dbg_data_o !== 32'hA5000007) begin tests_failed++; $display("[TB] FAIL load_capture7: got %h expected a5000007", dbg_data_o); end
    for (int i = 0; i < 3; i++) step();
    dbg_load = 1'b1;
    dbg_load_addr = 5'd20;
    step();
    dbg_load = 1'b0;
    #1;
    tests_run++;
    if (dbg_addr_o !== 5'd20) begin tests_failed++; $display("[TB] FAIL load_vs_advance: got %0d expected 20", dbg_addr_o); end
    tests_run++;
    if (dm_bus.re !== 1'b1 || dm_bus.addr !== 9'd80) begin
      tests_failed++;
      $display("[TB] FAIL load_enters_req: got re=%b addr=%0d expected 1/80", dm_bus.re, dm_bus.addr);
    end
    step();
    tests_run++;
    if (dbg_valid_o !== 1'b1 || dbg_data_o !== 32'hA5000014) begin
      tests_failed++;
      $display("[TB] FAIL load_capture20: got valid=%b data=%h expected 1/a5000014", dbg_valid_o, dbg_data_o);
    end
    for (int i = 0; i < 4; i++) step();
    dbg_load = 1'b1;
    dbg_load_addr = 5'd9;
    step();
    dbg_load = 1'b0;
    tests_run++;
    if (dbg_data_o !== 32'hA5000015 || dbg_addr_o !== 5'd9) begin
      tests_failed++;
      $display("[TB] FAIL load_in_req: got data=%h addr=%0d expected a5000015/9", dbg_data_o, dbg_addr_o);
    end
  endtask

  task automatic test_mid_reset();
    step();
    rstn = 1'b0;
    #1;
    tests_run++;
    if (dbg_addr_o !== 5'd0 || dbg_data_o !== 32'h0 || dbg_valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: got addr=%0d data=%h valid=%b expected 0/0/0", dbg_addr_o, dbg_data_o, dbg_valid_o);
    end
    tests_run++;
    if (dm_bus.re !== 1'b0 || dm_bus.addr !== 9'h010) begin
      tests_failed++;
      $display("[TB] FAIL midreset_mux: got re=%b addr=%h expected 0/010", dm_bus.re, dm_bus.addr);
    end
    step();
    rstn = 1'b1;
    step();
    tests_run++;
    if (dm_bus.re !== 1'b1 || dm_bus.addr !== 9'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_restart_req: got re=%b addr=%0d expected 1/0", dm_bus.re, dm_bus.addr);
    end
    step();
    tests_run++;
    if (dbg_valid_o !== 1'b1 || dbg_data_o !== 32'hA5000000 || dbg_addr_o !== 5'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_restart_capture: got valid=%b data=%h addr=%0d expected 1/a5000000/0", dbg_valid_o, dbg_data_o, dbg_addr_o);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA5000000 + i;
    mem[3] = 32'hDEADBEEF;
    cpu_idle();
    dbg_scan_en   = 1'b0;
    dbg_pause     = 1'b0;
    dbg_load      = 1'b0;
    dbg_load_addr = 5'd0;
    test_reset();
    test_scan();
    test_conflict();
    test_wrap_pause();
    test_load();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dm_debug_arbiter.md
# dm_debug_arbiter

Shares the single data-memory port between the single-cycle CPU and a debug scan reader that feeds the seven-segment display path. The CPU always has priority and is never stalled. The debug side steals idle memory cycles, walks a window of word addresses with a programmable dwell, and holds the last captured word for display. The block sits between the CPU data-memory outputs and the dm instance in the top level.

## Interface
Parameters:
- ADDR_W, 9: dm byte-address width.
- DATA_W, 32: data width.
- SCAN_WORDS, 32: words in the scan window; must be a power of two with clog2(SCAN_WORDS)+2 <= ADDR_W.
- HOLD_CYCLES, 4: dwell cycles per address after a capture; must be >= 1.

Ports:
- clk, in, 1: single clock; all state on its rising edge.
- rstn, in, 1: asynchronous, active-low reset.
- cpu_we / cpu_re, in, 1 each: CPU memory write and read.
- cpu_type, in, 3: CPU DMType.
- cpu_addr, in, ADDR_W: CPU address.
- cpu_wdata, in, DATA_W: CPU store data.
- cpu_rdata, out, DATA_W: load data returned to the CPU.
- dm_we / dm_re, out, 1 each: write and read strobes to dm.
- dm_type, out, 3: DMType to dm.
- dm_addr, out, ADDR_W: address to dm.
- dm_din, out, DATA_W: write data to dm.
- dm_dout, in, DATA_W: dm read data (combinational).
- dbg_scan_en, in, 1: enables scanning.
- dbg_pause, in, 1: freezes the address but keeps refreshing the current word.
- dbg_load, in, 1: loads dbg_load_addr.
- dbg_load_addr, in, clog2(SCAN_WORDS): word index to load.
- dbg_addr_o, out, clog2(SCAN_WORDS): current word index.
- dbg_data_o, out, DATA_W: last captured word.
- dbg_valid_o, out, 1: one-cycle pulse on each capture.
- conflict_cnt_o, out, 16: present only with DM_DEBUG_ARB_STATS_EN.

## Operation
- Slot free when cpu_we==0 && cpu_re==0.
- Grant = slot free && state==REQ.
- Combinational mux:
  - dm_we = cpu_we; debug never writes.
  - dm_din = cpu_wdata.
  - dm_re = cpu_re | grant.
  - dm_addr = grant ? {dbg_addr_o, 2'b00} zero-extended to ADDR_W : cpu_addr.
  - dm_type = grant ? DM_TYPE_WORD : cpu_type.
  - cpu_rdata = dm_dout, unconditionally.
- FSM states are IDLE, REQ, HOLD.
  - IDLE: entered from any state when dbg_scan_en==0. dbg_data_o and dbg_addr_o are retained. Goes to REQ when dbg_scan_en==1.
  - REQ: on a grant edge, dbg_data_o <= dm_dout, dbg_valid_o <= 1, hold_cnt <= 0, then go to HOLD. With no grant the FSM waits indefinitely and there is no timeout.
  - HOLD: hold_cnt increments each cycle. When hold_cnt==HOLD_CYCLES-1, go to REQ. On that edge the address advances by 1 unless dbg_pause==1. The address wraps from SCAN_WORDS-1 to 0.
- dbg_load loads the address in any state. It takes effect on the same edge and wins over a simultaneous advance.
  - In HOLD, a load also forces the next state to REQ and clears hold_cnt.
  - A load while in REQ keeps the FSM in REQ.
  - The capture on that same edge uses the old address.

## Timing
- Reset values: state IDLE; dbg_addr_o 0; dbg_data_o 0; dbg_valid_o 0; hold_cnt 0; conflict_cnt_o 0. Combinational outputs follow the CPU inputs.
- Capture latency: a grant in cycle N gives dbg_data_o and dbg_valid_o valid after edge N.
- The period per address with a continuously free slot is HOLD_CYCLES+1 cycles.
- dbg_valid_o is high for exactly one cycle per capture and is 0 in every other cycle.
- Reset asserted mid-scan clears immediately; the FSM restarts from IDLE after release.
- The CPU path has zero added latency and zero stall in every state.

## Configuration
- DM_DEBUG_ARB_STATS_EN defined:
  - conflict_cnt_o increments on every cycle where state==REQ and the slot is busy.
  - The counter saturates at 16'hFFFF.
  - It is cleared only by reset.
- DM_DEBUG_ARB_STATS_EN undefined: the port and the counter are absent, with no other behaviour change.

## Structure
- DM_TYPE_WORD and the FSM state encodings belong in the shared macro/package file alongside the existing DMType codes.
- One sub-module is natural: dm_debug_scan_seq, containing the FSM, hold counter and address register. The arbiter top holds only the mux and the stats counter.

## Test plan
- CPU idle, SCAN_WORDS=32, HOLD_CYCLES=4, word 3 preloaded 32'hDEADBEEF:
  - dbg_load to 3, then scan_en.
  - dbg_data_o = 32'hDEADBEEF.
  - Valid pulses every 5 cycles.
  - Address steps 3, 4, 5.
- CPU holds cpu_re=1 for 10 cycles while the FSM is in REQ:
  - No capture occurs.
  - dm_addr = cpu_addr throughout.
  - The capture happens in the first free cycle.
  - conflict_cnt_o = 10 when stats are enabled.
- Address 31 with pause=0: wraps to 0. With pause=1: stays at 31, re-captures every 5 cycles, and picks up a CPU store of 32'h12345678 to byte address 124.
- dbg_load=1 coinciding with a HOLD-end advance at address 7 with load_addr 20: dbg_addr_o = 20 and the FSM enters REQ.
- rstn pulsed low mid-HOLD: all outputs return to their reset values asynchronously, and scanning restarts at address 0 after release.
